// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: parity mode encodings,
// the transmit FSM state type and a frame-length helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10,
    PAR_MARK = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP1,
    ST_STOP2
  } tx_state_e;

  // Number of baud ticks one frame occupies on the line.
  function automatic int unsigned frame_len(input int unsigned data_w,
                                            input logic par_en,
                                            input logic two_stop);
    return 1 + data_w + (par_en ? 1 : 0) + (two_stop ? 2 : 1);
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// System-side write interface of the UART transmitter.
//   wr_en/wr_data : write strobe and word (master -> slave)
//   full          : FIFO full, write refused
//   overflow      : one-clk pulse for a write attempted while full
//   level         : words queued (FIFO plus holding register)
interface uart_tx_frame_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LVL_W  = 5
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              overflow;
  logic [LVL_W-1:0]  level;

  modport master (output wr_en, output wr_data,
                  input  full,  input  overflow, input level);
  modport slave  (input  wr_en, input  wr_data,
                  output full,  output overflow, output level);
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered read data (show-ahead off): rd_data
// holds the popped word from the cycle after rd_en.
//   clk, RSTn        : clock, asynchronous active-low reset
//   wr_en, wr_data   : push (ignored when full)
//   rd_en, rd_data   : pop (ignored when empty), registered output
//   full, empty      : status from the registered count
//   count            : number of stored words
module uart_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              do_wr, do_rd;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = rd_data_q;

  always_comb begin
    do_wr     = wr_en && !full;
    do_rd     = rd_en && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_rd) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: write FIFO, one-word holding register and a framing
// FSM that shifts data LSB first, one bit per baud_tick.
//   clk, RSTn        : clock, asynchronous active-low reset
//   baud_tick        : one-clk pulse per bit period
//   wr_if            : write port (wr_en, wr_data, full, overflow, level)
//   parity_mode      : 00 none, 01 odd, 10 even, 11 mark; latched per frame
//   stop2            : two stop bits when set; latched per frame
//   txd              : serial line, idle high
//   empty            : nothing queued and line idle
//   bps_en           : baud generator enable
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH + 2)
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic             baud_tick,
  uart_tx_frame_if.slave   wr_if,
  input  logic [1:0]       parity_mode,
  input  logic             stop2,
  output logic             txd,
  output logic             empty,
  output logic             bps_en
);
  localparam int unsigned BIT_W  = $clog2(DATA_W);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty, fifo_rd;
  logic [FCNT_W-1:0] fifo_count;

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d, shift_q, shift_d;
  logic              hold_v_q, hold_v_d, pend_q, pend_d;
  logic [BIT_W-1:0]  cnt_q, cnt_d;
  logic              txd_q, txd_d, par_bit_q, par_bit_d;
  logic              two_stop_q, two_stop_d, ovf_q, ovf_d;
  parity_e           par_mode_q, par_mode_d;
  logic              start_frame, frame_end;
  logic [LVL_W-1:0]  level_w;

  uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .CNT_W(FCNT_W)) u_fifo (
    .clk     (clk),
    .RSTn    (RSTn),
    .wr_en   (wr_if.wr_en),
    .wr_data (wr_if.wr_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // A popped word spends one cycle in flight (pend_q) before it lands in the
  // holding register, so level counts it there instead of keeping a separate
  // up/down counter; the sum changes only on accepted writes and frame starts.
  assign fifo_rd = !hold_v_q && !pend_q && !fifo_empty;
  assign level_w = LVL_W'(fifo_count) + LVL_W'(pend_q) + LVL_W'(hold_v_q);

  assign wr_if.full     = fifo_full;
  assign wr_if.overflow = ovf_q;
  assign wr_if.level    = level_w;
  assign txd            = txd_q;
  assign bps_en         = (level_w != '0) || (state_q != ST_IDLE);
  assign empty          = !bps_en;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_v_d    = hold_v_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    txd_d       = txd_q;
    par_bit_d   = par_bit_q;
    par_mode_d  = par_mode_q;
    two_stop_d  = two_stop_q;
    start_frame = 1'b0;
    frame_end   = 1'b0;
    ovf_d       = wr_if.wr_en && fifo_full;
    pend_d      = fifo_rd;

    if (pend_q) begin
      hold_d   = fifo_rdata;
      hold_v_d = 1'b1;
    end

    if (baud_tick) begin
      case (state_q)
        ST_IDLE:  if (hold_v_q) start_frame = 1'b1;
        ST_START: begin
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          if (cnt_q < BIT_W'(DATA_W - 1)) begin
            cnt_d   = cnt_q + BIT_W'(1);
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end else if (par_mode_q != PAR_NONE) begin
            state_d = ST_PAR;
            txd_d   = par_bit_q;
          end else begin
            state_d = ST_STOP1;
            txd_d   = 1'b1;
          end
        end
        ST_PAR: begin
          state_d = ST_STOP1;
          txd_d   = 1'b1;
        end
        ST_STOP1: begin
          if (two_stop_q) state_d = ST_STOP2;
          else            frame_end = 1'b1;
        end
        ST_STOP2: frame_end = 1'b1;
        default:  state_d = ST_IDLE;
      endcase

      // Chaining on the frame-end tick keeps consecutive frames gap-free.
      if (frame_end) begin
        if (hold_v_q) begin
          start_frame = 1'b1;
        end else begin
          state_d = ST_IDLE;
          txd_d   = 1'b1;
        end
      end
    end

    if (start_frame) begin
      txd_d      = 1'b0;
      state_d    = ST_START;
      shift_d    = hold_q;
      hold_v_d   = 1'b0;
      par_mode_d = parity_e'(parity_mode);
      two_stop_d = stop2;
      case (parity_e'(parity_mode))
        PAR_ODD:  par_bit_d = ~^hold_q;
        PAR_EVEN: par_bit_d = ^hold_q;
        default:  par_bit_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      pend_q     <= 1'b0;
      shift_q    <= '0;
      cnt_q      <= '0;
      txd_q      <= 1'b1;
      par_bit_q  <= 1'b0;
      par_mode_q <= PAR_NONE;
      two_stop_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_v_q   <= hold_v_d;
      pend_q     <= pend_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      txd_q      <= txd_d;
      par_bit_q  <= par_bit_d;
      par_mode_q <= par_mode_d;
      two_stop_q <= two_stop_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;
  import uart_pkg::*;

  // bits: line values in time order, first bit at the MSB end, right-justified
  typedef struct packed { logic [15:0] bits; logic [4:0] len; } frame_t;
  typedef struct {
    logic [7:0]  data;
    logic [1:0]  pm;
    logic        st2;
    logic [15:0] exp_bits;
    int unsigned exp_len;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       RSTn, baud_tick, tick_en, stop2;
  logic [1:0] parity_mode;
  logic       txd8, txd5, empty8, empty5, bps8, bps5;

  uart_tx_frame_if #(.DATA_W(8), .LVL_W(5)) if8 ();
  uart_tx_frame_if #(.DATA_W(5), .LVL_W(5)) if5 ();

  uart_tx_frame #(.DATA_W(8), .FIFO_DEPTH(16), .LVL_W(5)) dut8 (
    .clk(clk), .RSTn(RSTn), .baud_tick(baud_tick), .wr_if(if8),
    .parity_mode(parity_mode), .stop2(stop2),
    .txd(txd8), .empty(empty8), .bps_en(bps8));

  uart_tx_frame #(.DATA_W(5), .FIFO_DEPTH(16), .LVL_W(5)) dut5 (
    .clk(clk), .RSTn(RSTn), .baud_tick(baud_tick), .wr_if(if5),
    .parity_mode(parity_mode), .stop2(stop2),
    .txd(txd5), .empty(empty5), .bps_en(bps5));

  int unsigned n_checks, n_pass, tick_num, div;
  frame_t      exp_q8[$], exp_q5[$];
  int unsigned start_t8[$], end_t8[$];
  logic        m_active[2];
  int          m_idx[2];
  logic [15:0] m_got[2];
  frame_t      m_cur[2];
  int unsigned m_done[2], m_unexp[2];
  vec_t        tbl[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  function automatic frame_t make_frame(input logic [8:0] d, input int dw,
                                        input logic [1:0] pm, input logic s2);
    frame_t f;
    logic   x;
    f.bits = '0; f.len = '0; x = 1'b0;
    f.bits = {f.bits[14:0], 1'b0}; f.len++;
    for (int i = 0; i < dw; i++) begin
      f.bits = {f.bits[14:0], d[i]}; f.len++; x ^= d[i];
    end
    if (pm != 2'b00) begin
      f.bits = {f.bits[14:0], (pm == 2'b01) ? ~x : (pm == 2'b10) ? x : 1'b1};
      f.len++;
    end
    f.bits = {f.bits[14:0], 1'b1}; f.len++;
    if (s2) begin f.bits = {f.bits[14:0], 1'b1}; f.len++; end
    return f;
  endfunction

  // Called once per baud tick with the line value driven for this bit period.
  task automatic mon_step(input int k, input logic tx);
    string nm;
    nm = (k == 0) ? "frame8" : "frame5";
    if (m_active[k] && m_idx[k] < int'(m_cur[k].len)) begin
      m_got[k] = {m_got[k][14:0], tx};
      m_idx[k]++;
      if (m_idx[k] == int'(m_cur[k].len)) begin
        check(nm, 32'(m_got[k]), 32'(m_cur[k].bits));
        m_done[k]++;
      end
    end else begin
      if (m_active[k] && k == 0) end_t8.push_back(tick_num);
      m_active[k] = 1'b0;
      if (tx == 1'b0) begin
        if ((k == 0) ? (exp_q8.size() == 0) : (exp_q5.size() == 0)) begin
          m_unexp[k]++;
        end else begin
          m_cur[k]    = (k == 0) ? exp_q8.pop_front() : exp_q5.pop_front();
          m_active[k] = 1'b1;
          m_idx[k]    = 1;
          m_got[k]    = 16'h0000;
          if (k == 0) start_t8.push_back(tick_num);
        end
      end
    end
  endtask

  task automatic write8(input logic [7:0] d);
    @(negedge clk); if8.wr_en = 1'b1; if8.wr_data = d;
    @(negedge clk); if8.wr_en = 1'b0;
  endtask

  task automatic write5(input logic [4:0] d);
    @(negedge clk); if5.wr_en = 1'b1; if5.wr_data = d;
    @(negedge clk); if5.wr_en = 1'b0;
  endtask

  task automatic wait_done(input int k, input int unsigned target,
                           input int unsigned budget, input string name);
    int unsigned c = 0;
    while (m_done[k] < target && c < budget) begin @(negedge clk); c++; end
    check(name, m_done[k], target);
  endtask

  task automatic wait_idle(input int k, input int unsigned budget);
    int unsigned c = 0;
    while (((k == 0) ? bps8 : bps5) && c < budget) begin @(negedge clk); c++; end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    frame_t f;
    logic [7:0] d;
    int unsigned base;
    int unsigned c;

    n_checks = 0; n_pass = 0; tick_num = 0; div = 0;
    m_active = '{1'b0, 1'b0}; m_idx = '{0, 0}; m_got = '{16'h0, 16'h0};
    m_done = '{0, 0}; m_unexp = '{0, 0};
    RSTn = 1'b0; baud_tick = 1'b0; tick_en = 1'b0; stop2 = 1'b0;
    parity_mode = PAR_NONE;
    if8.wr_en = 1'b0; if8.wr_data = '0; if5.wr_en = 1'b0; if5.wr_data = '0;

    tbl[0] = '{8'hA5, PAR_NONE, 1'b0, 16'b0101001011,   10};
    tbl[1] = '{8'h07, PAR_EVEN, 1'b0, 16'b01110000011,  11};
    tbl[2] = '{8'h07, PAR_ODD,  1'b0, 16'b01110000001,  11};
    tbl[3] = '{8'h03, PAR_MARK, 1'b0, 16'b01100000011,  11};
    tbl[4] = '{8'h3C, PAR_EVEN, 1'b1, 16'b000111100011, 12};
    tbl[5] = '{8'hFF, PAR_ODD,  1'b0, 16'b01111111111,  11};
    tbl[6] = '{8'h00, PAR_EVEN, 1'b1, 16'b000000000011, 12};

    // Baud generator and line monitor share one process so the sample of
    // each tick happens before the next tick value is driven.
    fork
      forever begin
        @(negedge clk);
        if (!RSTn) begin
          m_active = '{1'b0, 1'b0};
          exp_q8.delete();
          exp_q5.delete();
        end else if (baud_tick) begin
          tick_num++;
          mon_step(0, txd8);
          mon_step(1, txd5);
        end
        baud_tick = tick_en && (div % 16 == 15);
        div++;
      end
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_txd", txd8, 1);
    check("rst_full", if8.full, 0);
    check("rst_empty", empty8, 1);
    check("rst_level", if8.level, 0);
    check("rst_overflow", if8.overflow, 0);
    check("rst_bps_en", bps8, 0);
    check("rst_txd5", txd5, 1);
    check("rst_empty5", empty5, 1);
    RSTn = 1'b1;
    repeat (2) @(negedge clk);
    tick_en = 1'b1;

    // Table: single frames with assorted parity/stop settings
    for (int i = 0; i < 7; i++) begin
      base = m_done[0];
      @(negedge clk);
      parity_mode = tbl[i].pm;
      stop2 = tbl[i].st2;
      f.bits = tbl[i].exp_bits;
      f.len = 5'(tbl[i].exp_len);
      exp_q8.push_back(f);
      write8(tbl[i].data);
      wait_done(0, base + 1, 16 * 16 + 64, "table_frame_done");
      wait_idle(0, 64);
      check("table_idle_empty", empty8, 1);
      check("table_idle_txd", txd8, 1);
    end

    // DATA_W=5 odd parity; parity/stop inputs changed mid-frame must not matter
    base = m_done[1];
    parity_mode = PAR_ODD; stop2 = 1'b0;
    f.bits = 16'b00110101; f.len = 5'd8;
    exp_q5.push_back(f);
    write5(5'b10110);
    c = 0;
    while (!(m_active[1] && m_idx[1] >= 3) && c < 200) begin @(negedge clk); c++; end
    check("dw5_midframe_reached", (m_active[1] && m_idx[1] >= 3), 1);
    parity_mode = PAR_NONE; stop2 = 1'b1;
    wait_done(1, base + 1, 16 * 16, "dw5_frame_done");
    wait_idle(1, 64);
    check("dw5_idle_empty", empty5, 1);

    // Three back-to-back 8N1 frames: 30 ticks, no gaps
    parity_mode = PAR_NONE; stop2 = 1'b0;
    tick_en = 1'b0;
    repeat (20) @(negedge clk);
    start_t8.delete(); end_t8.delete();
    base = m_done[0];
    exp_q8.push_back(make_frame(9'h011, 8, PAR_NONE, 1'b0));
    exp_q8.push_back(make_frame(9'h022, 8, PAR_NONE, 1'b0));
    exp_q8.push_back(make_frame(9'h033, 8, PAR_NONE, 1'b0));
    write8(8'h11); write8(8'h22); write8(8'h33);
    repeat (4) @(negedge clk);
    check("b2b_level", if8.level, 3);
    tick_en = 1'b1;
    wait_done(0, base + 3, 3 * 10 * 16 + 100, "b2b_frames_done");
    wait_idle(0, 64);
    check("b2b_frame_count", {start_t8.size() == 3, end_t8.size() == 3}, 2'b11);
    if (start_t8.size() == 3 && end_t8.size() == 3) begin
      check("b2b_total_ticks", end_t8[2] - start_t8[0], 30);
      check("b2b_no_gap_1", start_t8[1], end_t8[0]);
      check("b2b_no_gap_2", start_t8[2], end_t8[1]);
    end

    // Fill to FIFO_DEPTH+1 with ticks stopped, then overflow
    tick_en = 1'b0;
    repeat (20) @(negedge clk);
    base = m_done[0];
    for (int i = 0; i < 17; i++) begin
      d = 8'($urandom_range(0, 255));
      exp_q8.push_back(make_frame({1'b0, d}, 8, PAR_NONE, 1'b0));
      write8(d);
    end
    repeat (2) @(negedge clk);
    check("fill_level", if8.level, 17);
    check("fill_full", if8.full, 1);
    check("fill_no_overflow", if8.overflow, 0);
    @(negedge clk); if8.wr_en = 1'b1; if8.wr_data = 8'hEE;
    @(negedge clk); if8.wr_en = 1'b0;
    check("overflow_pulse", if8.overflow, 1);
    check("overflow_level", if8.level, 17);
    @(negedge clk);
    check("overflow_one_cycle", if8.overflow, 0);
    check("overflow_level_hold", if8.level, 17);
    tick_en = 1'b1;
    wait_done(0, base + 17, 17 * 10 * 16 + 200, "fill_frames_done");
    wait_idle(0, 64);
    check("fill_queue_drained", exp_q8.size(), 0);
    check("fill_empty", empty8, 1);

    // Reset during DATA bit 3 with words queued
    tick_en = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      exp_q8.push_back(make_frame(9'h055, 8, PAR_NONE, 1'b0));
      write8(8'h55);
    end
    tick_en = 1'b1;
    c = 0;
    while (!(m_active[0] && m_idx[0] == 5) && c < 400) begin @(negedge clk); c++; end
    check("rst_mid_reached", (m_active[0] && m_idx[0] == 5), 1);
    check("rst_mid_line_low", txd8, 0);
    RSTn = 1'b0;
    #1;
    check("rst_mid_txd_async", txd8, 1);
    repeat (3) @(negedge clk);
    RSTn = 1'b1;
    @(negedge clk);
    check("rst_mid_level", if8.level, 0);
    check("rst_mid_full", if8.full, 0);
    repeat (60 * 16) @(negedge clk);
    check("rst_mid_no_residue", m_unexp[0], 0);
    check("rst_mid_txd_idle", txd8, 1);
    check("rst_mid_empty", empty8, 1);

    check("no_unexpected5", m_unexp[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter with an internal write FIFO, runtime-selectable parity and stop-bit count, and configurable data width.
- Bytes are written from the system side.
- Frames are serialised LSB-first on txd, one bit per baud_tick pulse supplied by the shared baud generator.
- Back-to-back frames are sent with no idle gap.
- Next-generation TX path for the serial debug/insitu link.

Parameters:
DATA_W, 8, data bits per frame; legal 5..9
FIFO_DEPTH, 16, write FIFO entries; power of two, >=2
LVL_W, $clog2(FIFO_DEPTH+2), width of the level output

Ports:
clk  input  1  system clock
RSTn  input  1  asynchronous active-low reset
baud_tick  input  1  one-clk pulse per bit period, from the baud generator
wr_data  input  DATA_W  word to transmit
wr_en  input  1  write strobe; accepted only when full=0
parity_mode  input  2  00 none, 01 odd, 10 even, 11 mark (constant 1)
stop2  input  1  1 = two stop bits, 0 = one
txd  output  1  serial line, idle high
full  output  1  FIFO full; write not accepted
empty  output  1  FIFO, holding register and shifter all empty, line idle
level  output  LVL_W  words queued: FIFO count plus holding register
overflow  output  1  one-clk pulse when wr_en is asserted while full
bps_en  output  1  high while any word is queued or a frame is active; gates the baud generator

Behaviour:
- Decided interface: reset RSTn, asynchronous, active-low; clock clk.
- Reset values: txd=1, full=0, empty=1, level=0, overflow=0, bps_en=0. FIFO, holding register and FSM are cleared.
- Reset mid-frame: txd returns to 1 asynchronously. The partial frame and all queued data are discarded, and no residue is transmitted after release.
- Write path:
  - wr_en && !full writes wr_data into the FIFO at the clock edge.
  - wr_en && full drops the word and pulses overflow for 1 cycle.
  - full is evaluated before any same-cycle pop, so a write to a full FIFO is dropped even if a pop occurs in the same cycle.
- Prefetch: whenever the holding register is empty and the FIFO is not empty, pop 1 word into the holding register on the next edge. The holding register plus FIFO give a capacity of FIFO_DEPTH+1 words.
- FSM states: IDLE, START, DATA, PAR, STOP1, STOP2. All transitions occur only on cycles with baud_tick=1. Each bit is driven on txd from one tick to the next.
- Frame start (IDLE, tick, holding register valid):
  - txd<=0, enter START.
  - Load the holding word into the shifter and clear the holding register.
  - Latch parity_mode and stop2. Changes to these inputs mid-frame have no effect.
- START, tick: drive data bit 0, enter DATA, bit counter=0.
- DATA, tick:
  - If bit counter < DATA_W-1: counter++, drive the next bit (LSB first).
  - Otherwise, enter PAR if parity is enabled, else STOP1.
- Parity bit values: even = XOR of the DATA_W data bits; odd = inverse of that XOR; mark = 1.
- Entry to PAR or STOP1 drives the parity bit or txd=1 respectively.
- STOP1, tick: if stop2 was latched, enter STOP2 (txd stays 1). Otherwise the frame ends.
- STOP2, tick: the frame ends.
- Frame-end tick: if the holding register is valid, start the next frame on the same tick (txd<=0, enter START); otherwise go to IDLE with txd=1. No gap cycles between frames.
- baud_tick in IDLE with no valid holding word has no effect.
- Frame length in ticks: 1 + DATA_W + (parity?1:0) + (stop2?2:1).
- level increments on an accepted write and decrements when a frame start consumes the holding word. A FIFO-to-holding transfer does not change level. Simultaneous write and consume leave level unchanged.
- bps_en = (level!=0) || (state!=IDLE).
- empty = !bps_en.

Decomposition:
- Shared package uart_pkg:
  - parity mode encodings PAR_NONE/PAR_ODD/PAR_EVEN/PAR_MARK;
  - FSM state enum;
  - helper function computing frame length.
- Sub-module uart_sync_fifo (DATA_W x FIFO_DEPTH):
  - registered output, show-ahead off;
  - provides full/empty/count.
- The FSM and shifter live in the top module.

Test Plan:
- DATA_W=8, parity none, stop2=0, write 0xA5, tick every 16 clk -> txd over 10 ticks = 0,1,0,1,0,0,1,0,1,1; bps_en falls after last stop tick; empty=1.
- Even parity, write 0x07 -> parity bit 1 after bit 7. Odd parity, 0x07 -> parity bit 0. Mark parity -> 1. Stop2=1 -> frame length 12 ticks.
- Write 0x11, 0x22, 0x33 back-to-back, 8N1 -> exactly 30 ticks from first start bit to end of last stop. Start bit of each following frame begins on the preceding frame's stop-end tick.
- baud_tick held 0, 17 writes accepted (level=17, full=1), 18th write -> overflow pulse for 1 cycle, level stays 17. Enable ticks -> 17 frames sent in order.
- Assert RSTn low at DATA bit 3 of a frame with 4 words queued -> txd=1 immediately; after release level=0, no further frames sent on subsequent ticks.
- DATA_W=5, odd parity, write 5'b10110 -> txd 0,0,1,1,0,1,0,1 (8 ticks); toggling parity_mode mid-frame leaves the frame unchanged.
